// File: rtl/high_level_decryptor.sv
// Iterative AES-128 decryptor: one round per clock, round keys derived on the fly.
// The forward key schedule is run up to round key 10, then inverted one step per round.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   ciphertext      128-bit block to decrypt (bits [127:120] = state byte 0)
//   aes_key         128-bit cipher key (same byte order)
//   start_aes       request, sampled only in IDLE
//   plaintext       registered result
//   decryptor_done  level, high while plaintext is valid
//   busy            high while an operation is in flight
module high_level_decryptor #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] ciphertext,
  input  logic [127:0] aes_key,
  input  logic         start_aes,
  output logic [127:0] plaintext,
  output logic         decryptor_done,
  output logic         busy
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;

  typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, FINAL} state_t;

  state_t             st_q, st_d;
  logic [BLK_W-1:0]   blk_q, blk_d, key_q, key_d, plaintext_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic               done_d, busy_d;

  // GF(2^8) arithmetic, polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      p = gf_mul(p, s);
    end
    return p;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c-r+4)%4)+r)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*(15-i) +: 8] = aes_inv_sbox(s[8*(15-i) +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c)   +: 8];
      a1 = s[8*(14-4*c)   +: 8];
      a2 = s[8*(13-4*c)   +: 8];
      a3 = s[8*(12-4*c)   +: 8];
      o[8*(15-4*c) +: 8] = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
      o[8*(14-4*c) +: 8] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
      o[8*(13-4*c) +: 8] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
      o[8*(12-4*c) +: 8] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Key schedule datapath: the four S-box lookups are shared between the
  // forward step (RotWord of w3) and the inverse step (RotWord of the new w3).
  logic [31:0]  w3_prev, sub_src, sub_rot, sub_word, rcon_word;
  logic [127:0] key_fwd, key_inv, inv_sb, round_out;

  always_comb begin
    w3_prev   = key_q[31:0] ^ key_q[63:32];
    sub_src   = (st_q == KEYEXP) ? key_q[31:0] : w3_prev;
    sub_rot   = {sub_src[23:0], sub_src[31:24]};
    for (int b = 0; b < 4; b++) sub_word[8*b +: 8] = aes_sbox(sub_rot[8*b +: 8]);
    rcon_word = {rcon(rnd_q), 24'h000000};

    key_fwd[127:96] = key_q[127:96] ^ sub_word ^ rcon_word;
    key_fwd[95:64]  = key_q[95:64]  ^ key_fwd[127:96];
    key_fwd[63:32]  = key_q[63:32]  ^ key_fwd[95:64];
    key_fwd[31:0]   = key_q[31:0]   ^ key_fwd[63:32];

    key_inv[31:0]   = w3_prev;
    key_inv[63:32]  = key_q[63:32] ^ key_q[95:64];
    key_inv[95:64]  = key_q[95:64] ^ key_q[127:96];
    key_inv[127:96] = key_q[127:96] ^ sub_word ^ rcon_word;

    inv_sb    = inv_sub_bytes(inv_shift_rows(blk_q));
    round_out = inv_mix_columns(inv_sb ^ key_inv);
  end

  // Next-state and datapath control
  always_comb begin
    st_d        = st_q;
    blk_d       = blk_q;
    key_d       = key_q;
    rnd_d       = rnd_q;
    plaintext_d = plaintext;
    done_d      = decryptor_done;
    busy_d      = busy;
    case (st_q)
      IDLE: begin
        if (start_aes) begin
          blk_d  = ciphertext;
          key_d  = aes_key;
          rnd_d  = RND_W'(1);
          st_d   = KEYEXP;
          busy_d = 1'b1;
          done_d = 1'b0;
        end
      end
      KEYEXP: begin
        key_d = key_fwd;
        if (rnd_q == RND_W'(NR)) st_d = ADDKEY;
        else                     rnd_d = rnd_q + RND_W'(1);
      end
      ADDKEY: begin
        blk_d = blk_q ^ key_q;
        rnd_d = RND_W'(NR);
        st_d  = ROUND;
      end
      ROUND: begin
        key_d = key_inv;
        blk_d = round_out;
        rnd_d = rnd_q - RND_W'(1);
        if (rnd_q == RND_W'(2)) st_d = FINAL;
      end
      FINAL: begin
        key_d       = key_inv;
        plaintext_d = inv_sb ^ key_inv;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        rnd_d       = '0;
        st_d        = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q           <= IDLE;
      blk_q          <= '0;
      key_q          <= '0;
      rnd_q          <= '0;
      plaintext      <= '0;
      decryptor_done <= 1'b0;
      busy           <= 1'b0;
    end else begin
      st_q           <= st_d;
      blk_q          <= blk_d;
      key_q          <= key_d;
      rnd_q          <= rnd_d;
      plaintext      <= plaintext_d;
      decryptor_done <= done_d;
      busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_high_level_decryptor.sv
// Directed bench for high_level_decryptor: known-answer vectors, latency,
// start-while-busy, mid-operation reset and back-to-back starts.
module tb_high_level_decryptor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] ciphertext, aes_key, plaintext;
  logic         start_aes, decryptor_done, busy;

  high_level_decryptor #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .ciphertext(ciphertext), .aes_key(aes_key),
    .start_aes(start_aes), .plaintext(plaintext),
    .decryptor_done(decryptor_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    logic [127:0] rk10;
    bit           chk_rk;
  } vec_t;

  vec_t vecs[4];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait for done after the accepting edge; returns edges counted (40 = timed out)
  task automatic wait_done(input vec_t v, input string tag, output int n);
    n = 0;
    while (!decryptor_done && n < 40) begin
      tick();
      n++;
      if (n == 10 && v.chk_rk) check128({tag, "_rk10"}, dut.key_q, v.rk10);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    aes_key    = v.key;
    ciphertext = v.ct;
    start_aes  = 1'b1;
    tick();
    start_aes  = 1'b0;
    check1({tag, "_busy_on_accept"}, busy, 1'b1);
    check1({tag, "_done_cleared"}, decryptor_done, 1'b0);
    wait_done(v, tag, n);
    check_int({tag, "_latency"}, n, 21);
    check128({tag, "_plaintext"}, plaintext, v.pt);
    check1({tag, "_busy_after_done"}, busy, 1'b0);
    tick();
    tick();
    check1({tag, "_done_level"}, decryptor_done, 1'b1);
    check128({tag, "_plaintext_hold"}, plaintext, v.pt);
  endtask

  initial begin
    int   n;
    bit   saw_done;
    vec_t alt;

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt: 128'h00112233445566778899aabbccddeeff, rk10: 128'h13111d7fe3944a17f307a78b4d2b30c5, chk_rk: 1'b1};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3925841d02dc09fbdc118597196a0b32,
                pt: 128'h3243f6a8885a308d313198a2e0370734, rk10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, chk_rk: 1'b1};
    vecs[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                pt: 128'h6bc1bee22e409f96e93d7e117393172a, rk10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, chk_rk: 1'b1};
    vecs[3] = '{key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                pt: 128'h0, rk10: 128'h0, chk_rk: 1'b0};

    // Reset, with a start request that reset must override
    rst_n      = 1'b0;
    start_aes  = 1'b1;
    ciphertext = vecs[0].ct;
    aes_key    = vecs[0].key;
    tick();
    tick();
    check128("reset_plaintext", plaintext, 128'h0);
    check1("reset_done", decryptor_done, 1'b0);
    check1("reset_busy", busy, 1'b0);
    start_aes = 1'b0;
    rst_n     = 1'b1;
    tick();
    check1("idle_busy", busy, 1'b0);

    // Known-answer table
    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start while busy: second request at E+5 with other inputs is ignored
    aes_key    = vecs[0].key;
    ciphertext = vecs[0].ct;
    start_aes  = 1'b1;
    tick();
    start_aes  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    aes_key    = vecs[1].key;
    ciphertext = vecs[1].ct;
    start_aes  = 1'b1;
    tick();
    start_aes  = 1'b0;
    check1("busy_poke_still_busy", busy, 1'b1);
    alt = vecs[0];
    alt.chk_rk = 1'b0;
    wait_done(alt, "busy_poke", n);
    check_int("busy_poke_latency", n + 5, 21);
    check128("busy_poke_plaintext", plaintext, vecs[0].pt);

    // Reset at E+8 aborts, no done follows
    aes_key    = vecs[0].key;
    ciphertext = vecs[0].ct;
    start_aes  = 1'b1;
    tick();
    start_aes  = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    tick();
    check128("midrst_plaintext", plaintext, 128'h0);
    check1("midrst_done", decryptor_done, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (decryptor_done || busy) saw_done = 1'b1;
    end
    check1("midrst_no_activity", saw_done, 1'b0);
    run_vec(vecs[0], "after_rst");

    // Back-to-back with start held high
    aes_key    = vecs[0].key;
    ciphertext = vecs[0].ct;
    start_aes  = 1'b1;
    tick();
    alt = vecs[0];
    alt.chk_rk = 1'b0;
    wait_done(alt, "b2b0", n);
    check_int("b2b0_latency", n, 21);
    check128("b2b0_plaintext", plaintext, vecs[0].pt);
    aes_key    = vecs[1].key;
    ciphertext = vecs[1].ct;
    tick();
    check1("b2b1_accept_done_low", decryptor_done, 1'b0);
    check1("b2b1_accept_busy", busy, 1'b1);
    start_aes = 1'b0;
    alt = vecs[1];
    wait_done(alt, "b2b1", n);
    check_int("b2b1_latency", n, 21);
    check128("b2b1_plaintext", plaintext, vecs[1].pt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
